hd_harness_seq: RTL and testbench
=================================

Name: hd_harness_seq

Overview:
- Parametrised sequencer for hardware-design test harnesses. Replaces the hard-wired pattern "AND-reduce user input into a core start; slice the core result into 2-bit lanes; AND lane results pairwise onto 8 output pins".
- Adds a real start/finish handshake with waitrequest back-pressure, a result latch, and a finish timeout.
- Adds lane-enable windowing, re-trigger lockout, and configurable lane/output widths.
- Sits between top-level user I/O, one compute core (dfadd-class) and NUM_CH downstream lane consumers (viterbi-class).

Parameters:
- DATA_W, 32: core result width; must equal NUM_CH*LANE_W.
- NUM_CH, 16: number of downstream lanes.
- LANE_W, 2: bits per lane.
- IN_W, 8: user input width.
- OUT_W, 8: design output width; NUM_CH must be a multiple of OUT_W.
- TIMEOUT, 1024: maximum WAIT cycles before abort; must be ≥2.
- LANE_HOLD, 4: cycles lane_en_o stays high per result; must be ≥1.
- TRIG_MODE, 0: 0 = level (AND of userInput_o), 1 = rising edge of that AND.

Ports:
- clk_o, input, 1: single clock.
- rst_o, input, 1: asynchronous, active-low reset.
- userInput_o, input, IN_W: user trigger bits.
- core_start_o, output, 1: start request to core.
- core_waitrequest_i, input, 1: core not ready to accept start.
- core_finish_i, input, 1: one-cycle core completion pulse.
- core_result_i, input, DATA_W: core return value; valid with finish.
- lane_data_o, output, DATA_W: lane k = bits [k*LANE_W +: LANE_W].
- lane_en_o, output, NUM_CH: per-lane enable; all bits move together.
- lane_res_i, input, NUM_CH: per-lane result bits.
- designOutput_i, output, OUT_W: registered reduced output.
- busy_o, output, 1: high in every state except IDLE.
- timeout_o, output, 1: sticky; set when the last run aborted.

Behaviour:
- Reset (rst_o=0, asynchronous): state=IDLE; cnt=0; result register=0.
- Reset values: core_start_o=0, lane_data_o=0, lane_en_o=0, designOutput_i=0, busy_o=0, timeout_o=0.
- Reset mid-run: abandons the run; no state survives.
- trig: level mode = &userInput_o; edge mode = &userInput_o & ~prev, where prev is a registered copy of the AND (reset to 0).
- IDLE -> START on trig. Clear timeout_o on this transition.
- START:
  - core_start_o=1.
  - Start is accepted when core_start_o=1 and core_waitrequest_i=0; on acceptance go to WAIT with cnt=0.
  - While waitrequest=1, hold core_start_o high and stay in START (unbounded wait).
  - core_finish_i is ignored in START.
- WAIT:
  - core_start_o=0; cnt increments each cycle.
  - core_finish_i=1: latch core_result_i and go to DRAIN.
  - Else if cnt==TIMEOUT-1: result:=0, set timeout_o, go to DRAIN.
  - Finish on the terminal-count cycle wins; timeout_o stays 0.
- DRAIN:
  - lane_data_o=result register; lane_en_o all ones.
  - Lasts exactly LANE_HOLD cycles (cnt reused, cleared on entry); then HOLD.
- HOLD:
  - lane_en_o=0. lane_data_o keeps the last result until the next DRAIN.
  - Level mode: go to IDLE only once &userInput_o==0 (re-trigger lockout).
  - Edge mode: go to IDLE next cycle.
- Triggers are ignored outside IDLE. There is no queueing.
- Output reduction, registered every cycle regardless of state:
  - G = NUM_CH/OUT_W.
  - designOutput_i[j] = AND of lane_res_i[j*G +: G], with j=0 fed by the lowest lanes.
  - MSB is additionally ANDed with done, where done = 1 in DRAIN/HOLD and timeout_o==0.
- Latency: trig to core_start_o is 1 cycle. lane_res_i to designOutput_i is 1 cycle.
- Finish-to-lane_en latency is 1 cycle.
- cnt width = clog2(max(TIMEOUT, LANE_HOLD))+1. cnt saturates; it never wraps.

Decomposition:
- Package hd_harness_pkg holds:
  - state enum {IDLE, START, WAIT, DRAIN, HOLD};
  - clog2-based count-width function;
  - elaboration-time parameter legality checks (DATA_W==NUM_CH*LANE_W, NUM_CH%OUT_W==0).
- One sub-module, hd_lane_reduce: parametrised grouped AND plus the output register.

Test Plan:
- Level trigger: userInput_o=8'hFF, waitrequest=0, finish after 5 cycles with result 32'hA5A5_F00F.
  - core_start_o high exactly 1 cycle; lane_en_o=16'hFFFF for 4 cycles; lane 0 = 2'b11, lane 15 = 2'b10.
  - busy_o falls only after userInput_o returns to 0.
- Back-pressure: waitrequest=1 for 7 cycles after start.
  - core_start_o held high 8 cycles; finish pulsed during START is ignored and does not latch.
- Timeout: TIMEOUT=16, no finish.
  - After 16 WAIT cycles: timeout_o=1, lane_data_o=0; designOutput_i[7]=0 even with lane_res_i all ones.
- Finish and terminal count in the same cycle: result latched, timeout_o=0.
- Reset asserted mid-WAIT: all outputs 0 immediately, asynchronously.
  - After release with userInput_o still 8'hFF (level mode): a new START follows 1 cycle later.
- Edge mode, userInput_o held 8'hFF through a whole run: exactly one run, then IDLE with no re-trigger.
  - Dropping the input and re-raising it starts a second run.

Source files
------------

// File: rtl/hd_harness_pkg.sv
// hd_harness_pkg
// Shared definitions for the hd_harness_seq sequencer.
//   hd_state_e      : sequencer states (IDLE, START, WAIT, DRAIN, HOLD)
//   hd_cnt_width    : width of the shared WAIT/DRAIN counter
//   hd_params_legal : parameter legality check, evaluated at elaboration
package hd_harness_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } hd_state_e;

    // One extra bit above clog2 so the terminal values of both the timeout
    // window and the lane hold window are always representable.
    function automatic int hd_cnt_width(input int timeout, input int hold);
        int biggest;
        biggest = (timeout > hold) ? timeout : hold;
        return $clog2(biggest) + 1;
    endfunction

    // The lane slicing and output grouping only make sense when the result
    // splits exactly into lanes and the lanes split exactly into output pins.
    function automatic bit hd_params_legal(input int data_w, input int num_ch,
                                           input int lane_w, input int out_w,
                                           input int timeout, input int hold);
        bit ok;
        ok = 1'b1;
        if (data_w != num_ch * lane_w) ok = 1'b0;
        if (out_w < 1)                 ok = 1'b0;
        else if (num_ch % out_w != 0)  ok = 1'b0;
        if (timeout < 2)               ok = 1'b0;
        if (hold < 1)                  ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/hd_lane_reduce.sv
// hd_lane_reduce
// Folds the per-lane result bits down onto the design output pins and
// registers them. Pin j is the AND of lane group j (lowest lanes on pin 0);
// the top pin is additionally qualified with done_i.
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset
//   lane_res_i : per-lane result bits, NUM_CH wide
//   done_i     : run completed without timeout
//   reduced_o  : registered reduced output, OUT_W wide
module hd_lane_reduce #(
    parameter int NUM_CH = 16,
    parameter int OUT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NUM_CH-1:0] lane_res_i,
    input  logic              done_i,
    output logic [OUT_W-1:0]  reduced_o
);

    localparam int G = NUM_CH / OUT_W;

    logic [OUT_W-1:0] grouped;
    logic [OUT_W-1:0] reduce_d;
    logic [OUT_W-1:0] reduce_q;

    // Each output pin is the AND of its own contiguous lane group.
    for (genvar j = 0; j < OUT_W; j++) begin : g_group
        assign grouped[j] = &lane_res_i[j*G +: G];
    end

    // The top pin only reports success once the run has actually finished
    // cleanly, so a timed-out or in-flight run can never look like a pass.
    always_comb begin
        reduce_d            = grouped;
        reduce_d[OUT_W-1]   = grouped[OUT_W-1] & done_i;
    end

    // Output register, updated every cycle regardless of sequencer state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reduce_q <= '0;
        end else begin
            reduce_q <= reduce_d;
        end
    end

    assign reduced_o = reduce_q;

endmodule

// File: rtl/hd_harness_seq.sv
// hd_harness_seq
// Test-harness sequencer: turns the user trigger into a start/finish
// handshake with one compute core, latches its result, fans the result out
// to NUM_CH lane consumers for LANE_HOLD cycles and folds the lane results
// back onto OUT_W registered output pins.
//   clk_o              : clock
//   rst_o              : asynchronous active-low reset
//   userInput_o        : user trigger bits (all ones = trigger)
//   core_start_o       : start request to core, held while waitrequest
//   core_waitrequest_i : core cannot accept start yet
//   core_finish_i      : one-cycle completion pulse, result valid with it
//   core_result_i      : core result
//   lane_data_o        : latched result, lane k = bits [k*LANE_W +: LANE_W]
//   lane_en_o          : all-ones while lanes are being driven
//   lane_res_i         : per-lane result bits
//   designOutput_i     : registered reduced lane results
//   busy_o             : sequencer not idle
//   timeout_o          : sticky, last run aborted on timeout
module hd_harness_seq
    import hd_harness_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 16,
    parameter int LANE_W    = 2,
    parameter int IN_W      = 8,
    parameter int OUT_W     = 8,
    parameter int TIMEOUT   = 1024,
    parameter int LANE_HOLD = 4,
    parameter int TRIG_MODE = 0
) (
    input  logic              clk_o,
    input  logic              rst_o,
    input  logic [IN_W-1:0]   userInput_o,
    output logic              core_start_o,
    input  logic              core_waitrequest_i,
    input  logic              core_finish_i,
    input  logic [DATA_W-1:0] core_result_i,
    output logic [DATA_W-1:0] lane_data_o,
    output logic [NUM_CH-1:0] lane_en_o,
    input  logic [NUM_CH-1:0] lane_res_i,
    output logic [OUT_W-1:0]  designOutput_i,
    output logic              busy_o,
    output logic              timeout_o
);

    if (!hd_params_legal(DATA_W, NUM_CH, LANE_W, OUT_W, TIMEOUT, LANE_HOLD))
    begin : g_param_error
        $error("hd_harness_seq: illegal parameter combination");
    end

    localparam int               CNT_W      = hd_cnt_width(TIMEOUT, LANE_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LANE_HOLD - 1);

    hd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              prev_q;

    logic              allOnes;
    logic              trig;
    logic [CNT_W-1:0]  cntInc;
    logic              done;

    // Edge mode compares against last cycle's AND so a held input only
    // fires once; level mode fires whenever the input is all ones.
    assign allOnes = &userInput_o;
    assign trig    = (TRIG_MODE != 0) ? (allOnes & ~prev_q) : allOnes;

    // The counter saturates rather than wrapping so a stuck count can never
    // alias back onto a terminal value.
    assign cntInc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State register plus the datapath registers that move with it. Reset
    // abandons any run in flight and clears everything, including the
    // trigger history.
    always_ff @(posedge clk_o or negedge rst_o) begin
        if (!rst_o) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            prev_q    <= allOnes;
        end
    end

    // Next-state logic. The counter is shared: it times the WAIT window,
    // then is cleared and reused to time the DRAIN window. A finish pulse
    // takes priority over the terminal count in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cntInc;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (trig) begin
                    state_d   = START;
                    timeout_d = 1'b0;
                end
            end
            START: begin
                cnt_d = '0;
                if (!core_waitrequest_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_finish_i) begin
                    result_d = core_result_i;
                    state_d  = DRAIN;
                    cnt_d    = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                    cnt_d     = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                cnt_d = '0;
                // Level mode waits for the user to let go, otherwise a held
                // input would immediately start another run.
                if ((TRIG_MODE != 0) || !allOnes) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the current state. The lane data simply shows
    // the result register, which only changes on entry to DRAIN, so it
    // naturally holds the last result between runs.
    always_comb begin
        core_start_o = 1'b0;
        lane_en_o    = '0;
        busy_o       = 1'b1;
        done         = 1'b0;
        case (state_q)
            IDLE:    busy_o       = 1'b0;
            START:   core_start_o = 1'b1;
            DRAIN: begin
                lane_en_o = '1;
                done      = ~timeout_q;
            end
            HOLD:    done         = ~timeout_q;
            default: ;
        endcase
    end

    assign lane_data_o = result_q;
    assign timeout_o   = timeout_q;

    hd_lane_reduce #(
        .NUM_CH (NUM_CH),
        .OUT_W  (OUT_W)
    ) u_lane_reduce (
        .clk_i      (clk_o),
        .rst_n_i    (rst_o),
        .lane_res_i (lane_res_i),
        .done_i     (done),
        .reduced_o  (designOutput_i)
    );

endmodule

// File: tb/tb_hd_harness_seq.sv
// tb_hd_harness_seq
// Self-checking bench for hd_harness_seq. One level-mode instance with a
// short timeout carries the main randomized runs; a second edge-mode
// instance checks single-shot triggering with a held input.
module tb_hd_harness_seq;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_HOLD    = 4;

    logic clock = 1'b0;
    logic resetN;

    // Level-mode instance signals
    logic [7:0]  userInput;
    logic        coreStart;
    logic        waitReq;
    logic        finish;
    logic [31:0] result;
    logic [31:0] laneData;
    logic [15:0] laneEn;
    logic [15:0] laneRes;
    logic [7:0]  designOut;
    logic        busy;
    logic        timeoutFlag;

    // Edge-mode instance signals
    logic [7:0]  eUser;
    logic        eStart;
    logic        eWait;
    logic        eFinish;
    logic [31:0] eResult;
    logic [31:0] eLaneData;
    logic [15:0] eLaneEn;
    logic [15:0] eLaneRes;
    logic [7:0]  eDesignOut;
    logic        eBusy;
    logic        eTimeout;

    int checks = 0;
    int errors = 0;

    // Reference-model state
    logic [31:0] lastLane;
    bit          expDone;
    logic [7:0]  mdlOut;
    bit          monOn;

    always #5 clock = ~clock;

    hd_harness_seq #(
        .DATA_W(32), .NUM_CH(16), .LANE_W(2), .IN_W(8), .OUT_W(8),
        .TIMEOUT(TB_TIMEOUT), .LANE_HOLD(TB_HOLD), .TRIG_MODE(0)
    ) dutLevel (
        .clk_o              (clock),
        .rst_o              (resetN),
        .userInput_o        (userInput),
        .core_start_o       (coreStart),
        .core_waitrequest_i (waitReq),
        .core_finish_i      (finish),
        .core_result_i      (result),
        .lane_data_o        (laneData),
        .lane_en_o          (laneEn),
        .lane_res_i         (laneRes),
        .designOutput_i     (designOut),
        .busy_o             (busy),
        .timeout_o          (timeoutFlag)
    );

    hd_harness_seq #(
        .DATA_W(32), .NUM_CH(16), .LANE_W(2), .IN_W(8), .OUT_W(8),
        .TIMEOUT(TB_TIMEOUT), .LANE_HOLD(TB_HOLD), .TRIG_MODE(1)
    ) dutEdge (
        .clk_o              (clock),
        .rst_o              (resetN),
        .userInput_o        (eUser),
        .core_start_o       (eStart),
        .core_waitrequest_i (eWait),
        .core_finish_i      (eFinish),
        .core_result_i      (eResult),
        .lane_data_o        (eLaneData),
        .lane_en_o          (eLaneEn),
        .lane_res_i         (eLaneRes),
        .designOutput_i     (eDesignOut),
        .busy_o             (eBusy),
        .timeout_o          (eTimeout)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Output pin j passes when both bits of lane pair j are set; the top pin
    // additionally needs a clean finished run.
    function automatic logic [7:0] reduceModel(input logic [15:0] res, input bit done);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            r[j] = (((res >> (2 * j)) & 16'd3) == 16'd3);
        end
        r[7] = r[7] & done;
        return r;
    endfunction

    // Model of the registered reduction: captures what the pins should show
    // one cycle after the lane results are presented.
    always @(posedge clock) begin
        if (!resetN) mdlOut = 8'h00;
        else         mdlOut = reduceModel(laneRes, expDone);
    end

    // Compare the reduced pins every cycle, then present fresh lane results
    // biased towards all-ones so the done-qualified top pin gets exercised.
    always @(negedge clock) begin
        if (monOn) begin
            checkOutput("designOutput", 64'(designOut), 64'(mdlOut));
            laneRes = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
        end
    end

    // Idle cycles with a non-triggering input pattern.
    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            userInput = 8'($urandom) & ~(8'h1 << $urandom_range(0, 7));
            @(negedge clock);
            checkOutput("idleBusy",  64'(busy),      64'(0));
            checkOutput("idleStart", 64'(coreStart), 64'(0));
        end
    endtask

    // One complete level-mode run, called at a negedge while idle.
    //   waitCycles : cycles the core holds waitrequest after start
    //   finishAt   : WAIT cycle index of the finish pulse (>= timeout: none)
    //   pulseInStart : also pulse finish while start is still stalled
    //   holdCycles : extra cycles the input stays all-ones after the drain
    //   resetAt    : WAIT cycle index at which reset is asserted (-1: none)
    task automatic applyStimulus(input int waitCycles, input int finishAt,
                                 input logic [31:0] res, input bit pulseInStart,
                                 input int holdCycles, input int resetAt);
        logic [31:0] expLane;
        bit          expTo;
        userInput = 8'hFF;
        waitReq   = 1'b1;
        @(negedge clock);
        for (int k = 0; k <= waitCycles; k++) begin
            if (k > 0) @(negedge clock);
            checkOutput("startHigh", 64'(coreStart), 64'(1));
            checkOutput("busyStart", 64'(busy),      64'(1));
            if (k == 0) checkOutput("timeoutCleared", 64'(timeoutFlag), 64'(0));
            waitReq = (k < waitCycles);
            finish  = pulseInStart && (k == waitCycles - 1);
            result  = $urandom;
        end
        for (int m = 0; m < TB_TIMEOUT; m++) begin
            @(negedge clock);
            if (m == 0) begin
                checkOutput("startDropped", 64'(coreStart), 64'(0));
                checkOutput("laneDataHeld", 64'(laneData),  64'(lastLane));
            end
            checkOutput("laneEnWait", 64'(laneEn), 64'(0));
            checkOutput("busyWait",   64'(busy),   64'(1));
            if (m == resetAt) begin
                #2 resetN = 1'b0;
                #1;
                checkOutput("rstStart",     64'(coreStart),   64'(0));
                checkOutput("rstLaneEn",    64'(laneEn),      64'(0));
                checkOutput("rstLaneData",  64'(laneData),    64'(0));
                checkOutput("rstBusy",      64'(busy),        64'(0));
                checkOutput("rstTimeout",   64'(timeoutFlag), 64'(0));
                checkOutput("rstDesignOut", 64'(designOut),   64'(0));
                finish   = 1'b0;
                lastLane = 32'h0;
                expDone  = 1'b0;
                @(negedge clock);
                resetN = 1'b1;
                return;
            end
            waitReq = 1'($urandom_range(0, 1));
            finish  = (m == finishAt);
            result  = (m == finishAt) ? res : $urandom;
            if (m == finishAt) break;
        end
        expTo   = (finishAt > TB_TIMEOUT - 1);
        expLane = expTo ? 32'h0 : res;
        for (int d = 0; d < TB_HOLD; d++) begin
            @(negedge clock);
            if (d == 0) begin
                finish  = 1'b0;
                expDone = !expTo;
            end
            checkOutput("laneEnDrain",   64'(laneEn),      64'(16'hFFFF));
            checkOutput("laneDataDrain", 64'(laneData),    64'(expLane));
            checkOutput("timeoutDrain",  64'(timeoutFlag), 64'(expTo));
            checkOutput("startDrain",    64'(coreStart),   64'(0));
        end
        lastLane = expLane;
        for (int h = 0; h <= holdCycles; h++) begin
            @(negedge clock);
            checkOutput("laneEnHold",   64'(laneEn),   64'(0));
            checkOutput("busyHold",     64'(busy),     64'(1));
            checkOutput("laneDataHold", 64'(laneData), 64'(expLane));
            if (h == holdCycles) userInput = 8'($urandom) & ~(8'h1 << $urandom_range(0, 7));
        end
        @(negedge clock);
        expDone = 1'b0;
        checkOutput("busyIdle",     64'(busy),        64'(0));
        checkOutput("timeoutIdle",  64'(timeoutFlag), 64'(expTo));
        checkOutput("laneDataIdle", 64'(laneData),    64'(expLane));
    endtask

    // Watches the edge-mode instance for a fixed window, acting as a core
    // that finishes a few cycles after accepting start.
    task automatic edgeWindow(output int starts, output int runs,
                              output logic [31:0] latched);
        int cd;
        bit prevBusy;
        starts   = 0;
        runs     = 0;
        latched  = 32'h0;
        cd       = -1;
        prevBusy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            eFinish = 1'b0;
            if (eStart) begin
                starts++;
                cd = 3;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                eFinish = 1'b1;
                eResult = $urandom;
                latched = eResult;
                cd      = -1;
            end
            if (eBusy && !prevBusy) runs++;
            prevBusy = eBusy;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          starts;
        int          runs;
        logic [31:0] latched;

        resetN    = 1'b0;
        monOn     = 1'b0;
        userInput = 8'h00;
        waitReq   = 1'b0;
        finish    = 1'b0;
        result    = 32'h0;
        laneRes   = 16'h0;
        eUser     = 8'h00;
        eWait     = 1'b0;
        eFinish   = 1'b0;
        eResult   = 32'h0;
        eLaneRes  = 16'h0;
        lastLane  = 32'h0;
        expDone   = 1'b0;

        @(negedge clock);
        @(negedge clock);
        checkOutput("resetStart",     64'(coreStart),   64'(0));
        checkOutput("resetLaneEn",    64'(laneEn),      64'(0));
        checkOutput("resetLaneData",  64'(laneData),    64'(0));
        checkOutput("resetDesignOut", 64'(designOut),   64'(0));
        checkOutput("resetBusy",      64'(busy),        64'(0));
        checkOutput("resetTimeout",   64'(timeoutFlag), 64'(0));
        checkOutput("resetEdgeBusy",  64'(eBusy),       64'(0));

        resetN = 1'b1;
        monOn  = 1'b1;
        idleGap(2);

        // Basic level-triggered run with a known result
        applyStimulus(0, 5, 32'hA5A5_F00F, 1'b0, 2, -1);
        checkOutput("lane0",  64'(laneData[1:0]),   64'(2'b11));
        checkOutput("lane15", 64'(laneData[31:30]), 64'(2'b10));
        idleGap(1);

        // Back-pressure with a stray finish while start is stalled
        applyStimulus(7, 3, $urandom, 1'b1, 0, -1);

        // No finish at all: timeout abort
        applyStimulus(1, 100, 32'hDEAD_BEEF, 1'b0, 1, -1);

        // Finish on the terminal-count cycle
        applyStimulus(0, TB_TIMEOUT - 1, 32'h1234_5678, 1'b0, 0, -1);

        // Reset in the middle of WAIT, then an immediate new run
        applyStimulus(0, 10, 32'hCAFE_F00D, 1'b0, 0, 4);
        applyStimulus(0, 2, 32'h0F0F_1234, 1'b0, 1, -1);

        // Randomized runs
        for (int i = 0; i < 12; i++) begin
            idleGap($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 4), $urandom_range(0, 20), $urandom,
                          1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
        end

        // Edge mode: held input gives exactly one run
        eUser = 8'hFF;
        edgeWindow(starts, runs, latched);
        checkOutput("edgeStarts1",   64'(starts),    64'(1));
        checkOutput("edgeRuns1",     64'(runs),      64'(1));
        checkOutput("edgeIdle1",     64'(eBusy),     64'(0));
        checkOutput("edgeLaneData1", 64'(eLaneData), 64'(latched));

        // Dropping and re-raising the input starts a second run
        eUser = 8'h00;
        @(negedge clock);
        @(negedge clock);
        eUser = 8'hFF;
        edgeWindow(starts, runs, latched);
        checkOutput("edgeStarts2",   64'(starts),     64'(1));
        checkOutput("edgeRuns2",     64'(runs),       64'(1));
        checkOutput("edgeIdle2",     64'(eBusy),      64'(0));
        checkOutput("edgeLaneData2", 64'(eLaneData),  64'(latched));
        checkOutput("edgeLaneEn",    64'(eLaneEn),    64'(0));
        checkOutput("edgeTimeout",   64'(eTimeout),   64'(0));
        checkOutput("edgeDesignOut", 64'(eDesignOut), 64'(0));

        monOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
